// File: rtl/sr_ff_driver_if.sv
// Command/feedback bundle between a controller (master) and the SR flip-flop driver (slave).
// q_fb is carried here so the driver sees the driven element's output alongside the command.
interface sr_ff_driver_if #(
    parameter int HOLD_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_level;
    logic [HOLD_W-1:0] cmd_hold;
    logic              q_fb;
    logic              s;
    logic              r;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        err_cnt;

    modport master (
        output cmd_valid, cmd_level, cmd_hold, q_fb,
        input  cmd_ready, s, r, busy, done, err, err_cnt
    );

    modport slave (
        input  cmd_valid, cmd_level, cmd_hold, q_fb,
        output cmd_ready, s, r, busy, done, err, err_cnt
    );
endinterface

// File: rtl/sr_ff_driver.sv
// Turns "drive q to level L, then hold for N cycles" commands into registered S/R pulses,
// confirms the result through q feedback and reports done or a timeout error.
//
// state   | meaning
// IDLE    | ready for a command
// PULSE   | s or r asserted, counting PULSE_LEN cycles
// WAIT_Q  | waiting up to TIMEOUT cycles for q_fb to reach the target
// HOLD    | q confirmed (or already correct), counting the requested hold
module sr_ff_driver #(
    parameter int PULSE_LEN = 1,
    parameter int TIMEOUT   = 4,
    parameter int HOLD_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    sr_ff_driver_if.slave   bus
);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_Q,
        ST_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PW-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= 1'b0;
            hold_q      <= '0;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        hold_d      = hold_q;
        pulse_cnt_d = pulse_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        s_d         = s_q;
        r_d         = r_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    level_d = bus.cmd_level;
                    hold_d  = bus.cmd_hold;
                    // Already at the target level: skip the pulse entirely.
                    if (bus.q_fb == bus.cmd_level) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = bus.cmd_hold;
                    end else begin
                        state_d     = ST_PULSE;
                        s_d         = bus.cmd_level;
                        r_d         = ~bus.cmd_level;
                        pulse_cnt_d = PULSE_LAST;
                    end
                end
            end
            ST_PULSE: begin
                if (pulse_cnt_q == '0) begin
                    s_d       = 1'b0;
                    r_d       = 1'b0;
                    state_d   = ST_WAIT_Q;
                    tmo_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PW'(1);
                end
            end
            ST_WAIT_Q: begin
                if (bus.q_fb == level_q) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = hold_q;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
